// File: rtl/whack_round_ctrl_pkg.sv
// Shared definitions for the whack-a-mole round controller.
//   state_t      : FSM state encoding, also exported on o_state
//   POS_NONE     : mole position code meaning "no mole"
//   *_DEF        : default parameter values for the top level
//   pos_onehot() : maps a position code to a 5-bit lit-hole vector
package whack_round_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_POS = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_OVER     = 2'd3
    } state_t;

    localparam logic [2:0] POS_NONE        = 3'd5;
    localparam int         START_LIVES_DEF = 3;
    localparam int         SCORE_MAX_DEF   = 99;

    // Codes 5..7 light nothing.
    function automatic logic [4:0] pos_onehot(input logic [2:0] pos);
        logic [4:0] r;
        case (pos)
            3'd0:    r = 5'b00001;
            3'd1:    r = 5'b00010;
            3'd2:    r = 5'b00100;
            3'd3:    r = 5'b01000;
            3'd4:    r = 5'b10000;
            default: r = 5'b00000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/whack_round_ctrl_btn_edge.sv
// Registered rising-edge detector for the button levels.
//   i_clk, i_rst : clock and synchronous active-high reset
//   i_btn        : debounced button levels
//   o_rise       : one-cycle pulse per bit, one cycle after the level rises
// A held button yields a single pulse; history is cleared on reset.
module btn_edge #(
    parameter int W = 5
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_btn,
    output logic [W-1:0] o_rise
);

    logic [W-1:0] hist_q;
    logic [W-1:0] hist_d;
    logic [W-1:0] rise_q;
    logic [W-1:0] rise_d;

    always_comb begin
        hist_d = i_btn;
        rise_d = i_btn & ~hist_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hist_q <= '0;
            rise_q <= '0;
        end else begin
            hist_q <= hist_d;
            rise_q <= rise_d;
        end
    end

    assign o_rise = rise_q;

endmodule

// File: rtl/whack_round_ctrl.sv
// Round controller for a five-hole whack-a-mole game.
//   i_clk, i_rst        : clock and synchronous active-high reset
//   i_start             : start/restart request (honoured in IDLE/OVER)
//   i_btn[4:0]          : debounced button levels, bit n = hole n
//   i_mole_position     : position from the generator, 5 = none
//   i_position_changed  : generator has a new position this cycle
//   o_change_position   : one-cycle request for a new position
//   o_mole_onehot       : lit hole while a mole is active
//   o_score, o_lives    : saturating score, remaining lives
//   o_game_over, o_state: OVER flag and raw FSM state
// Every output comes straight from a flop.
module whack_round_ctrl
    import whack_round_ctrl_pkg::*;
#(
    parameter int START_LIVES = START_LIVES_DEF,
    parameter int SCORE_MAX   = SCORE_MAX_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [4:0] i_btn,
    input  logic [2:0] i_mole_position,
    input  logic       i_position_changed,
    output logic       o_change_position,
    output logic [4:0] o_mole_onehot,
    output logic [6:0] o_score,
    output logic [1:0] o_lives,
    output logic       o_game_over,
    output logic [1:0] o_state
);

    localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
    localparam logic [6:0] SCORE_TOP  = 7'(SCORE_MAX);

    logic [4:0] press;

    btn_edge #(.W(5)) u_btn_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_btn  (i_btn),
        .o_rise (press)
    );

    state_t     state_q, state_d;
    logic [2:0] pos_q, pos_d;
    logic [6:0] score_q, score_d;
    logic [1:0] lives_q, lives_d;
    logic       chg_q, chg_d;
    logic [4:0] onehot_q, onehot_d;
    logic       over_q, over_d;

    logic [4:0] target;
    logic       hit;
    logic       miss;

    always_comb begin
        target = pos_onehot(pos_q);
        // A hit needs the latched hole and nothing else in the same cycle.
        hit    = (press != 5'b0) && (press == target);
        miss   = (press != 5'b0) && !hit;

        state_d = state_q;
        pos_d   = pos_q;
        score_d = score_q;
        lives_d = lives_q;
        chg_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (i_start) begin
                    score_d = '0;
                    lives_d = LIVES_INIT;
                    chg_d   = 1'b1;
                    pos_d   = POS_NONE;
                    state_d = ST_WAIT_POS;
                end
            end
            ST_WAIT_POS: begin
                if (i_position_changed && (i_mole_position < POS_NONE)) begin
                    pos_d   = i_mole_position;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (hit) begin
                    // Hit outranks a simultaneous generator update.
                    if (score_q < SCORE_TOP) begin
                        score_d = score_q + 7'd1;
                    end
                    chg_d   = 1'b1;
                    pos_d   = POS_NONE;
                    state_d = ST_WAIT_POS;
                end else if (miss || i_position_changed) begin
                    // Miss and escape together still cost a single life.
                    if (lives_q != 2'd0) begin
                        lives_d = lives_q - 2'd1;
                    end
                    if (lives_q <= 2'd1) begin
                        pos_d   = POS_NONE;
                        state_d = ST_OVER;
                    end else if (i_position_changed) begin
                        if (i_mole_position < POS_NONE) begin
                            pos_d = i_mole_position;
                        end else begin
                            pos_d   = POS_NONE;
                            state_d = ST_WAIT_POS;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Derived from the next state so the display moves with the FSM.
        onehot_d = (state_d == ST_ACTIVE) ? pos_onehot(pos_d) : 5'b0;
        over_d   = (state_d == ST_OVER);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            pos_q    <= POS_NONE;
            score_q  <= '0;
            lives_q  <= LIVES_INIT;
            chg_q    <= 1'b0;
            onehot_q <= '0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            score_q  <= score_d;
            lives_q  <= lives_d;
            chg_q    <= chg_d;
            onehot_q <= onehot_d;
            over_q   <= over_d;
        end
    end

    assign o_change_position = chg_q;
    assign o_mole_onehot     = onehot_q;
    assign o_score           = score_q;
    assign o_lives           = lives_q;
    assign o_game_over       = over_q;
    assign o_state           = state_q;

endmodule

// File: tb/tb_whack_round_ctrl.sv
// Directed bench for whack_round_ctrl: a per-cycle vector table followed by
// hand-written hit/reset/saturation sequences.
module tb_whack_round_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] btn = 5'b0;
    logic [2:0] pos = 3'd5;
    logic       pchg = 1'b0;

    logic       o_chg;
    logic [4:0] o_oh;
    logic [6:0] o_score;
    logic [1:0] o_lives;
    logic       o_over;
    logic [1:0] o_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    whack_round_ctrl dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_start            (start),
        .i_btn              (btn),
        .i_mole_position    (pos),
        .i_position_changed (pchg),
        .o_change_position  (o_chg),
        .o_mole_onehot      (o_oh),
        .o_score            (o_score),
        .o_lives            (o_lives),
        .o_game_over        (o_over),
        .o_state            (o_state)
    );

    typedef struct {
        logic       rst;
        logic       start;
        logic [4:0] btn;
        logic [2:0] pos;
        logic       pchg;
        logic       chg;
        logic [4:0] oh;
        logic [6:0] score;
        logic [1:0] lives;
        logic       over;
        logic [1:0] st;
    } vec_t;

    function automatic vec_t v(input logic r, input logic s, input logic [4:0] b,
                               input logic [2:0] p, input logic pc, input logic c,
                               input logic [4:0] oh, input logic [6:0] sc,
                               input logic [1:0] l, input logic ov, input logic [1:0] st);
        vec_t x;
        x.rst = r; x.start = s; x.btn = b; x.pos = p; x.pchg = pc;
        x.chg = c; x.oh = oh; x.score = sc; x.lives = l; x.over = ov; x.st = st;
        return x;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Apply inputs at the falling edge, let one rising edge pass, return at the next falling edge.
    task automatic step(input logic r, input logic s, input logic [4:0] b,
                        input logic [2:0] p, input logic pc);
        rst = r; start = s; btn = b; pos = p; pchg = pc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input logic c, input logic [4:0] oh,
                           input logic [6:0] sc, input logic [1:0] l,
                           input logic ov, input logic [1:0] st);
        chk({tag, ".chg"},   int'(o_chg),   int'(c));
        chk({tag, ".oh"},    int'(o_oh),    int'(oh));
        chk({tag, ".score"}, int'(o_score), int'(sc));
        chk({tag, ".lives"}, int'(o_lives), int'(l));
        chk({tag, ".over"},  int'(o_over),  int'(ov));
        chk({tag, ".state"}, int'(o_state), int'(st));
    endtask

    // Deliver hole p, press it, and check the hit lands with the given score.
    task automatic do_hit(input logic [2:0] p, input logic [6:0] exp_score,
                          input logic [1:0] exp_lives, input string tag);
        logic [4:0] oh;
        oh = 5'b00001 << p;
        step(0, 0, 5'b0, p, 1);
        chk_all({tag, ".pos"}, 0, oh, exp_score == 7'd99 && o_score == 7'd99 ? 7'd99 : 7'(o_score), exp_lives, 0, 2);
        step(0, 0, oh, 3'd5, 0);
        chk({tag, ".press_wait"}, int'(o_state), 2);
        step(0, 0, oh, 3'd5, 0);
        chk_all({tag, ".hit"}, 1, 5'b0, exp_score, exp_lives, 0, 1);
        step(0, 0, 5'b0, 3'd5, 0);
        chk({tag, ".chg_off"}, int'(o_chg), 0);
        $display("hit pos=%0d score=%0d lives=%0d", p, o_score, o_lives);
    endtask

    vec_t tbl[32];

    initial begin
        tbl[0]  = v(1,0,5'b00000,5,0, 0,5'b00000,0,3,0,0);
        tbl[1]  = v(0,1,5'b00000,5,0, 1,5'b00000,0,3,0,1);
        tbl[2]  = v(0,0,5'b00000,5,0, 0,5'b00000,0,3,0,1);
        tbl[3]  = v(0,0,5'b00000,5,1, 0,5'b00000,0,3,0,1);
        tbl[4]  = v(0,0,5'b00000,2,1, 0,5'b00100,0,3,0,2);
        tbl[5]  = v(0,0,5'b00100,5,0, 0,5'b00100,0,3,0,2);
        tbl[6]  = v(0,0,5'b00100,5,0, 1,5'b00000,1,3,0,1);
        tbl[7]  = v(0,0,5'b00100,5,0, 0,5'b00000,1,3,0,1);
        tbl[8]  = v(0,0,5'b00000,4,1, 0,5'b10000,1,3,0,2);
        tbl[9]  = v(0,0,5'b10001,5,0, 0,5'b10000,1,3,0,2);
        tbl[10] = v(0,0,5'b10001,5,0, 0,5'b10000,1,2,0,2);
        tbl[11] = v(0,0,5'b00000,5,0, 0,5'b10000,1,2,0,2);
        tbl[12] = v(0,1,5'b00000,5,0, 0,5'b10000,1,2,0,2);
        tbl[13] = v(0,0,5'b00000,1,1, 0,5'b00010,1,1,0,2);
        tbl[14] = v(0,0,5'b00000,3,1, 0,5'b00000,1,0,1,3);
        tbl[15] = v(0,0,5'b00000,5,0, 0,5'b00000,1,0,1,3);
        tbl[16] = v(0,1,5'b00000,5,0, 1,5'b00000,0,3,0,1);
        tbl[17] = v(0,0,5'b00000,0,1, 0,5'b00001,0,3,0,2);
        tbl[18] = v(0,0,5'b00000,1,1, 0,5'b00010,0,2,0,2);
        tbl[19] = v(0,0,5'b00000,3,1, 0,5'b01000,0,1,0,2);
        tbl[20] = v(0,0,5'b00000,0,1, 0,5'b00000,0,0,1,3);
        tbl[21] = v(0,0,5'b00001,5,0, 0,5'b00000,0,0,1,3);
        tbl[22] = v(0,0,5'b00000,5,0, 0,5'b00000,0,0,1,3);
        tbl[23] = v(0,1,5'b00000,5,0, 1,5'b00000,0,3,0,1);
        tbl[24] = v(0,0,5'b00000,0,1, 0,5'b00001,0,3,0,2);
        tbl[25] = v(0,0,5'b00001,5,0, 0,5'b00001,0,3,0,2);
        tbl[26] = v(0,0,5'b00001,3,1, 1,5'b00000,1,3,0,1);
        tbl[27] = v(0,0,5'b00000,5,0, 0,5'b00000,1,3,0,1);
        tbl[28] = v(0,0,5'b00000,5,1, 0,5'b00000,1,3,0,1);
        tbl[29] = v(0,0,5'b00000,3,1, 0,5'b01000,1,3,0,2);
        tbl[30] = v(0,0,5'b00000,5,1, 0,5'b00000,1,2,0,1);
        tbl[31] = v(0,0,5'b00000,2,1, 0,5'b00100,1,2,0,2);

        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            step(tbl[i].rst, tbl[i].start, tbl[i].btn, tbl[i].pos, tbl[i].pchg);
            chk_all($sformatf("vec%0d", i), tbl[i].chg, tbl[i].oh, tbl[i].score,
                    tbl[i].lives, tbl[i].over, tbl[i].st);
            $display("vec %0d: chg=%0d oh=%b score=%0d lives=%0d over=%0d state=%0d",
                     i, o_chg, o_oh, o_score, o_lives, o_over, o_state);
        end

        // Five hits, then reset while a mole is active with score 5.
        step(1, 0, 5'b0, 3'd5, 0);
        chk_all("rst1", 0, 5'b0, 0, 3, 0, 0);
        step(0, 1, 5'b0, 3'd5, 0);
        chk_all("start_a", 1, 5'b0, 0, 3, 0, 1);
        for (int k = 0; k < 5; k++) begin
            do_hit(3'(k), 7'(k + 1), 2'd3, $sformatf("a%0d", k));
        end
        step(0, 0, 5'b0, 3'd2, 1);
        chk_all("active5", 0, 5'b00100, 5, 3, 0, 2);
        step(1, 1, 5'b11111, 3'd1, 1);
        chk_all("rst_mid", 0, 5'b0, 0, 3, 0, 0);
        $display("reset mid-game: state=%0d score=%0d chg=%0d", o_state, o_score, o_chg);
        step(0, 0, 5'b0, 3'd5, 0);
        chk_all("post_rst", 0, 5'b0, 0, 3, 0, 0);

        // Saturation: 100 hits, score must stop at 99.
        step(0, 1, 5'b0, 3'd5, 0);
        chk_all("start_b", 1, 5'b0, 0, 3, 0, 1);
        for (int k = 0; k < 100; k++) begin
            do_hit(3'(k % 5), (k + 1 > 99) ? 7'd99 : 7'(k + 1), 2'd3, $sformatf("s%0d", k));
        end
        chk("sat_final", int'(o_score), 99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
